// File: rtl/seq_divider.sv
// Sequential signed 32-bit divider with MIPS DIV semantics.
// A restoring divider that takes one quotient bit per cycle. The quotient
// truncates toward zero and the remainder takes the sign of the dividend.
// A zero divisor completes at once with div_zero set and leaves hi/lo as they were.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands are sampled on the start edge
// RUN   | 32 restoring-division steps, one per cycle
// FIX   | apply signs to quotient/remainder, register into lo/hi
// DONE  | one-cycle ready (and div_zero) pulse, then back to IDLE

module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        ready,
    output logic        div_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  count;
    logic [32:0] dvs;        // divisor magnitude; bit 32 keeps |0x80000000| exact
    logic [31:0] q;          // dividend magnitude shifting out, quotient shifting in
    logic [31:0] rem;        // partial remainder, always below the divisor magnitude
    logic        sign_q;
    logic        sign_r;

    logic [32:0] rem_shift;
    logic [32:0] diff;

    // Two's-complement magnitude widened to 33 bits so the most negative value is exact.
    function automatic logic [32:0] abs33(input logic [31:0] v);
        return v[31] ? (33'd0 - {1'b1, v}) : {1'b0, v};
    endfunction

    // One restoring step: shift the next dividend bit in, trial-subtract the divisor.
    always_comb begin
        rem_shift = {rem, q[31]};
        diff      = rem_shift - dvs;
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 6'd0;
            dvs      <= 33'd0;
            q        <= 32'd0;
            rem      <= 32'd0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            ready    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready    <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (b == 32'd0) begin
                            ready    <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            dvs    <= abs33(b);
                            q      <= 32'(abs33(a));
                            rem    <= 32'd0;
                            sign_q <= a[31] ^ b[31];
                            sign_r <= a[31];
                            count  <= 6'd32;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A borrow in bit 32 means the trial subtraction failed: restore.
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        q   <= {q[30:0], 1'b1};
                    end else begin
                        rem <= rem_shift[31:0];
                        q   <= {q[30:0], 1'b0};
                    end
                    count <= count - 6'd1;
                    if (count == 6'd1) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // 0x80000000 / -1 wraps back to 0x80000000 here, matching MIPS.
                    lo    <= sign_q ? (32'd0 - q) : q;
                    hi    <= sign_r ? (32'd0 - rem) : rem;
                    ready <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    ready    <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operands compared against a plain-arithmetic reference model.

module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ready;
    logic        div_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    seq_divider dut (
        .clk      (clk),
        .reset    (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .ready    (ready),
        .div_zero (div_zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: signed division in 64 bits, so -2^31 / -1 cannot overflow, then wrapped.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] qq, output logic [31:0] rr);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        qq = 32'(sx / sy);
        rr = 32'(sx % sy);
    endfunction

    // One request from IDLE. glitch_at > 0 pulses start (a=b=1) on that edge while busy;
    // start_in_done holds start high across the DONE cycle.
    task automatic run_div(input logic [31:0] da, input logic [31:0] db,
                           input int glitch_at, input bit start_in_done);
        logic [31:0] mq;
        logic [31:0] mr;
        @(negedge clk);
        a = da;
        b = db;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        if (db == 32'd0) begin
            chk1("dz_ready", ready, 1'b1);
            chk1("dz_flag", div_zero, 1'b1);
            chk1("dz_busy", busy, 1'b1);
            chk32("dz_lo_hold", lo, exp_lo);
            chk32("dz_hi_hold", hi, exp_hi);
            @(posedge clk);
            #1;
            chk1("dz_ready_off", ready, 1'b0);
            chk1("dz_flag_off", div_zero, 1'b0);
            chk1("dz_busy_off", busy, 1'b0);
            return;
        end
        model(da, db, mq, mr);
        chk1("busy_e0", busy, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            #1;
            if (k == glitch_at - 1) begin
                start = 1'b1;
                a = 32'd1;
                b = 32'd1;
            end else if (k == glitch_at) begin
                start = 1'b0;
            end
            chk1("busy_run", busy, 1'b1);
            if (k < 33) begin
                chk1("ready_early", ready, 1'b0);
            end
        end
        chk1("ready_e33", ready, 1'b1);
        chk1("divzero_nz", div_zero, 1'b0);
        chk32("lo", lo, mq);
        chk32("hi", hi, mr);
        exp_lo = mq;
        exp_hi = mr;
        if (start_in_done) begin
            start = 1'b1;
            a = $urandom;
            b = $urandom_range(1, 100);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk1("ready_pulse_end", ready, 1'b0);
        chk1("busy_idle", busy, 1'b0);
        @(posedge clk);
        #1;
        chk1("busy_stays_idle", busy, 1'b0);
        chk32("lo_hold", lo, exp_lo);
        chk32("hi_hold", hi, exp_hi);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        #2;
        chk32("rst_hi", hi, 32'd0);
        chk32("rst_lo", lo, 32'd0);
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_divzero", div_zero, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 0, 1'b0);
        run_div(32'd7, 32'd0, 0, 1'b0);
        run_div(32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_div(32'd7, 32'hFFFF_FFFE, 0, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(32'h8000_0000, 32'd2, 0, 1'b0);
        run_div(32'd100, 32'd7, 5, 1'b0);

        // Abort mid-operation with reset at E10.
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk32("abort_hi", hi, 32'd0);
        chk32("abort_lo", lo, 32'd0);
        chk1("abort_ready", ready, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_divzero", div_zero, 1'b0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            chk1("abort_no_ready", ready, 1'b0);
        end
        run_div(32'd9, 32'd3, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 20);
                3:       rb = 32'd0 - 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 31);
            run_div(ra, rb, (n % 3 == 0) ? int'($urandom_range(2, 30)) : 0, n[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
